// File: rtl/tick_gen_pkg.sv
// Shared types and constants for the multi-channel tick generator.
package tick_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    localparam int DEF_NCH   = 4;
    localparam int DEF_CNT_W = 10;
    localparam int DEF_PRE_W = 8;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: counts base ticks while running and emits a registered
// one-clock enable every period+1 base ticks (periodic) or once (one-shot).
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             base_tick,
    input  logic [CNT_W-1:0] period,
    input  logic             mode,
    input  logic             start,
    input  logic             stop,
    output logic             en,
    output logic             busy,
    output logic             done
);

    ch_state_t        state_p0, state_nx;
    logic [CNT_W-1:0] cnt_p0, cnt_nx;
    logic [CNT_W-1:0] per_p0, per_nx;
    logic             mode_p0, mode_nx;
    logic             en_p0, en_nx;
    logic             done_p0, done_nx;

    // Priority: stop over start over counting; a restart suppresses the pulse.
    always_comb begin
        state_nx = state_p0;
        cnt_nx   = cnt_p0;
        per_nx   = per_p0;
        mode_nx  = mode_p0;
        en_nx    = 1'b0;
        done_nx  = done_p0;
        if (stop) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (start) begin
            state_nx = RUN;
            cnt_nx   = '0;
            per_nx   = period;
            mode_nx  = mode;
            done_nx  = 1'b0;
        end else if (state_p0 == RUN && base_tick) begin
            if (cnt_p0 == per_p0) begin
                en_nx  = 1'b1;
                cnt_nx = '0;
                if (mode_p0 == MODE_ONESHOT) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    per_nx = period;
                end
            end else begin
                cnt_nx = cnt_p0 + CNT_W'(1);
            end
        end
    end

    // Stage p0: channel state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_p0 <= IDLE;
            cnt_p0   <= '0;
            per_p0   <= '0;
            mode_p0  <= MODE_PERIODIC;
            en_p0    <= 1'b0;
            done_p0  <= 1'b0;
        end else begin
            state_p0 <= state_nx;
            cnt_p0   <= cnt_nx;
            per_p0   <= per_nx;
            mode_p0  <= mode_nx;
            en_p0    <= en_nx;
            done_p0  <= done_nx;
        end
    end

    assign en   = en_p0;
    assign busy = (state_p0 == RUN);
    assign done = done_p0;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel tick generator: one shared free-running prescaler feeding
// NCH independent tick channels.
module tick_gen_multi
    import tick_gen_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [PRE_W-1:0]     prescale,
    input  logic [NCH*CNT_W-1:0] period,
    input  logic [NCH-1:0]       mode,
    input  logic [NCH-1:0]       start,
    input  logic [NCH-1:0]       stop,
    output logic [NCH-1:0]       en,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       done
);

    logic [PRE_W-1:0] pre_cnt_p0;
    logic             base_tick;

    // ">=" rather than "==" so a shrinking prescale ticks at once instead of wrapping.
    assign base_tick = (pre_cnt_p0 >= prescale);

    // Stage p0: prescaler, independent of channel start/stop
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pre_cnt_p0 <= '0;
        end else if (base_tick) begin
            pre_cnt_p0 <= '0;
        end else begin
            pre_cnt_p0 <= pre_cnt_p0 + PRE_W'(1);
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        tick_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .base_tick (base_tick),
            .period    (period[g*CNT_W +: CNT_W]),
            .mode      (mode[g]),
            .start     (start[g]),
            .stop      (stop[g]),
            .en        (en[g]),
            .busy      (busy[g]),
            .done      (done[g])
        );
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed self-checking bench for tick_gen_multi with hand-computed pulse patterns.
module tb_tick_gen_multi;

    localparam int NCH   = 4;
    localparam int CNT_W = 10;
    localparam int PRE_W = 8;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [PRE_W-1:0]     prescale;
    logic [NCH*CNT_W-1:0] period;
    logic [NCH-1:0]       mode;
    logic [NCH-1:0]       start;
    logic [NCH-1:0]       stop;
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0]       done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tick_gen_multi #(
        .NCH   (NCH),
        .CNT_W (CNT_W),
        .PRE_W (PRE_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .prescale (prescale),
        .period   (period),
        .mode     (mode),
        .start    (start),
        .stop     (stop),
        .en       (en),
        .busy     (busy),
        .done     (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_period(input int ch, input int p);
        period[ch*CNT_W +: CNT_W] = CNT_W'(p);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        start   = '0;
        stop    = '0;
        step();
        reset_n = 1'b1;
    endtask

    logic [31:0] pat;
    logic [31:0] pat_ch [NCH];
    int          acc;
    int          npulse;
    int          pos;

    initial begin
        reset_n  = 1'b0;
        prescale = '0;
        period   = '0;
        mode     = '0;
        start    = '0;
        stop     = '0;
        step();
        step();
        check_eq("reset_en",   32'(en),   32'h0);
        check_eq("reset_busy", 32'(busy), 32'h0);
        check_eq("reset_done", 32'(done), 32'h0);
        reset_n = 1'b1;

        // Reset behaviour: ch0 period 3, pulse every 4th clock, then reset at pulse edge
        set_period(0, 3);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        check_eq("r_busy0", 32'(busy[0]), 32'h1);
        check_eq("r_en0_start", 32'(en[0]), 32'h0);
        pat = '0;
        for (int i = 1; i <= 12; i++) begin
            step();
            pat[i-1] = en[0];
        end
        check_eq("r_pattern0", pat, 32'h888);
        step(); step(); step();
        reset_n = 1'b0;
        step();
        check_eq("r_mid_all", {20'h0, en, busy, done}, 32'h0);
        reset_n = 1'b1;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            acc = acc | int'(en) | int'(busy);
        end
        check_eq("r_after_idle", 32'(acc), 32'h0);

        // Prescaler and one-shot: prescale 4, ch1 period 2 -> en 14 clocks after start
        prescale = 8'd4;
        set_period(1, 2);
        mode[1] = 1'b1;
        pulse_reset();
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        check_eq("os_busy1", 32'(busy[1]), 32'h1);
        npulse = 0;
        pos    = 0;
        for (int i = 1; i <= 18; i++) begin
            step();
            if (en[1]) begin
                npulse++;
                pos = i;
            end
        end
        check_eq("os_npulse", 32'(npulse), 32'h1);
        check_eq("os_pos", 32'(pos), 32'd14);
        check_eq("os_busy_after", 32'(busy[1]), 32'h0);
        check_eq("os_done", 32'(done[1]), 32'h1);
        repeat (5) step();
        check_eq("os_done_held", 32'(done[1]), 32'h1);
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        check_eq("os_done_clr", 32'(done[1]), 32'h0);
        check_eq("os_rebusy", 32'(busy[1]), 32'h1);
        mode = '0;

        // Period update mid-interval: 5 -> 1 after the first pulse
        prescale = '0;
        pulse_reset();
        set_period(2, 5);
        start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        pat = '0;
        for (int i = 1; i <= 18; i++) begin
            step();
            pat[i-1] = en[2];
            if (i == 8) set_period(2, 1);
        end
        check_eq("pu_pattern2", pat, 32'h2A820);

        // Start/stop conflict and restart on ch3
        pulse_reset();
        set_period(3, 3);
        start[3] = 1'b1;
        step();
        start[3] = 1'b0;
        step(); step();
        start[3] = 1'b1;
        stop[3]  = 1'b1;
        step();
        start[3] = 1'b0;
        stop[3]  = 1'b0;
        check_eq("ss_busy3", 32'(busy[3]), 32'h0);
        check_eq("ss_en3", 32'(en[3]), 32'h0);
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            acc = acc | int'(en[3]) | int'(busy[3]);
        end
        check_eq("ss_idle3", 32'(acc), 32'h0);
        start[3] = 1'b1;
        step();
        start[3] = 1'b0;
        step(); step(); step();
        start[3] = 1'b1;
        step();
        start[3] = 1'b0;
        check_eq("rs_en3_suppr", 32'(en[3]), 32'h0);
        check_eq("rs_busy3", 32'(busy[3]), 32'h1);
        pat = '0;
        for (int i = 1; i <= 8; i++) begin
            step();
            pat[i-1] = en[3];
        end
        check_eq("rs_pattern3", pat, 32'h88);

        // Boundary: period 0 with prescale 0 -> en every clock
        pulse_reset();
        set_period(0, 0);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (en[0]) npulse++;
        end
        check_eq("b_p0_cont", 32'(npulse), 32'd10);

        // Boundary: prescale 200 -> 2 while prescaler count is 150
        prescale = 8'd200;
        pulse_reset();
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        acc = 0;
        for (int i = 0; i < 149; i++) begin
            step();
            acc = acc | int'(en[0]);
        end
        check_eq("b_pre_noticks", 32'(acc), 32'h0);
        check_eq("b_pre_busy", 32'(busy[0]), 32'h1);
        prescale = 8'd2;
        pat = '0;
        for (int i = 1; i <= 9; i++) begin
            step();
            pat[i-1] = en[0];
        end
        check_eq("b_pre_drop", pat, 32'h49);

        // Multi-channel: periods 0,1,3,7 all periodic
        prescale = '0;
        pulse_reset();
        set_period(0, 0);
        set_period(1, 1);
        set_period(2, 3);
        set_period(3, 7);
        start = 4'hF;
        step();
        start = '0;
        for (int c = 0; c < NCH; c++) pat_ch[c] = '0;
        npulse = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            for (int c = 0; c < NCH; c++) pat_ch[c][i-1] = en[c];
            if (en == 4'hF) npulse++;
        end
        check_eq("mc_ch0", pat_ch[0], 32'hFFFF);
        check_eq("mc_ch1", pat_ch[1], 32'hAAAA);
        check_eq("mc_ch2", pat_ch[2], 32'h8888);
        check_eq("mc_ch3", pat_ch[3], 32'h8080);
        check_eq("mc_coinc", 32'(npulse), 32'd2);
        check_eq("mc_busy", 32'(busy), 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
